// File: rtl/cla_pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
//   - mode_e      : operation encodings (ADD, SUB, ADDS, SUBS)
//   - max_pos()   : most positive two's complement value for a given width
//   - max_neg()   : most negative two's complement value for a given width
//   - is_sub()    : true for modes that compute a + ~b + 1
//   - is_sat()    : true for the saturating modes
// The saturation helpers return MAX_WIDTH-bit values; callers slice them.
// ---------------------------------------------------------------------------
package cla_pipe_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ADDS = 2'd2,
        MODE_SUBS = 2'd3
    } mode_e;

    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ONE_W = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

    // 0 followed by width-1 ones
    function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
        return (ONE_W << (width - 1)) - ONE_W;
    endfunction

    // 1 followed by width-1 zeros
    function automatic logic [MAX_WIDTH-1:0] max_neg(input int width);
        return ONE_W << (width - 1);
    endfunction

    function automatic logic is_sub(input mode_e m);
        return (m == MODE_SUB) || (m == MODE_SUBS);
    endfunction

    function automatic logic is_sat(input mode_e m);
        return (m == MODE_ADDS) || (m == MODE_SUBS);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// ---------------------------------------------------------------------------
// cla_group
// One GROUP-bit carry-lookahead block.
//   a, b   : group operand bits (b already inverted for subtraction)
//   cin    : carry into the least significant bit of the group
//   sum    : group sum bits
//   grp_p  : group propagate (carry-in passes straight through)
//   grp_g  : group generate  (group produces a carry on its own)
// grp_p/grp_g do not depend on cin and are computed in their own block, so
// the inter-group carry logic in the parent never forms a combinational loop.
// ---------------------------------------------------------------------------
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             grp_p,
    output logic             grp_g
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   gen_src;
    logic [GROUP-1:0] c;

    assign p       = a | b;
    assign g       = a & b;
    assign gen_src = {g, cin};

    // Fully expanded lookahead: c[i] is the OR over every source j <= i
    // (cin or a lower generate) ANDed with all propagates between j and i.
    always_comb begin
        logic term;
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gen_src[j];
                for (int k = j; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign sum = a ^ b ^ c;

    always_comb begin
        logic term;
        grp_p = &p;
        grp_g = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            term = g[j];
            for (int k = j + 1; k < GROUP; k++) begin
                term = term & p[k];
            end
            grp_g = grp_g | term;
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-lookahead adder/subtractor with Z/V/N flags,
// carry-out and optional signed saturation.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   a, b                : two's complement operands
//   mode                : 0=ADD 1=SUB 2=ADDS 3=SUBS
//   out_valid/out_ready : result handshake, results held while stalled
//   sum, cout           : result and raw carry out of the MSB
//   flag_z/v/n          : zero, unsaturated signed overflow, negative
// Stage 1 resolves the lower half and registers the half-way carry with the
// upper operands; stage 2 finishes the upper half and forms the flags.
// ---------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int HALF = WIDTH / 2;
    localparam int NG   = WIDTH / GROUP;
    localparam int NGH  = NG / 2;

    localparam logic [MAX_WIDTH-1:0] SAT_POS_W = max_pos(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_NEG_W = max_neg(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_POS   = SAT_POS_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG   = SAT_NEG_W[WIDTH-1:0];

    // Stage 1 registers
    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] lo_sum_q, lo_sum_d;
    logic            carry_q, carry_d;
    logic [HALF-1:0] a_hi_q, a_hi_d;
    logic [HALF-1:0] b_hi_q, b_hi_d;
    mode_e           mode_q, mode_d;

    // Stage 2 registers
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             n_q, n_d;

    mode_e            in_mode;
    logic             in_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] grp_sum;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_cin;
    logic             lo_cout;
    logic             hi_cout;
    logic [WIDTH-1:0] raw_sum;
    logic             ovf;
    logic [WIDTH-1:0] res;
    logic             s1_adv;
    logic             s2_adv;

    assign in_mode = mode_e'(mode);
    assign in_sub  = is_sub(in_mode);
    assign b_eff   = in_sub ? ~b : b;

    // Lower groups see the live operands, upper groups the stage-1 registers,
    // so one row of groups serves both pipeline stages.
    assign op_a = {a_hi_q, a[HALF-1:0]};
    assign op_b = {b_hi_q, b_eff[HALF-1:0]};

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a     (op_a[k*GROUP +: GROUP]),
            .b     (op_b[k*GROUP +: GROUP]),
            .cin   (grp_cin[k]),
            .sum   (grp_sum[k*GROUP +: GROUP]),
            .grp_p (grp_p[k]),
            .grp_g (grp_g[k])
        );
    end

    // Group-level carry chains: the lower chain starts from the subtract
    // carry-in, the upper chain restarts from the registered half-way carry.
    always_comb begin
        logic c;
        grp_cin = '0;
        c = in_sub;
        for (int k = 0; k < NGH; k++) begin
            grp_cin[k] = c;
            c = grp_g[k] | (grp_p[k] & c);
        end
        lo_cout = c;
        c = carry_q;
        for (int k = NGH; k < NG; k++) begin
            grp_cin[k] = c;
            c = grp_g[k] | (grp_p[k] & c);
        end
        hi_cout = c;
    end

    // Overflow is judged on the unsaturated sum; saturation picks the limit
    // on the side of operand A's sign.
    assign raw_sum = {grp_sum[WIDTH-1:HALF], lo_sum_q};
    assign ovf     = (a_hi_q[HALF-1] == b_hi_q[HALF-1]) &&
                     (raw_sum[WIDTH-1] != a_hi_q[HALF-1]);
    assign res     = (is_sat(mode_q) && ovf) ?
                     (a_hi_q[HALF-1] ? SAT_NEG : SAT_POS) : raw_sum;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Next-state: each stage loads only when it advances and has data
    // arriving; otherwise it holds, which keeps outputs stable under stall.
    always_comb begin
        s1_valid_d = s1_valid_q;
        lo_sum_d   = lo_sum_q;
        carry_d    = carry_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        mode_d     = mode_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        z_d        = z_q;
        v_d        = v_q;
        n_d        = n_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                lo_sum_d = grp_sum[HALF-1:0];
                carry_d  = lo_cout;
                a_hi_d   = a[WIDTH-1:HALF];
                b_hi_d   = b_eff[WIDTH-1:HALF];
                mode_d   = in_mode;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = res;
                cout_d = hi_cout;
                z_d    = (res == '0);
                v_d    = ovf;
                n_d    = res[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            carry_q    <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            mode_q     <= MODE_ADD;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            n_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            lo_sum_q   <= lo_sum_d;
            carry_q    <= carry_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            mode_q     <= mode_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            z_q        <= z_d;
            v_q        <= v_d;
            n_q        <= n_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign flag_z    = z_q;
    assign flag_v    = v_q;
    assign flag_n    = n_q;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the WISC-CPU execute datapath. It is built from 4-bit lookahead groups and supports add, subtract, and signed-saturating variants. It produces Z/V/N flags and carry-out, and uses a valid/ready handshake with full backpressure. It replaces ad-hoc ripple/CLA chains in the ALU, and the pipeline register lets WIDTH scale without lengthening the critical path.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 2*GROUP and at least 8.
GROUP, 4, bits per lookahead group.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/mode valid this cycle
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  operand A (two's complement)
b  in  WIDTH  operand B (two's complement)
mode  in  2  0=ADD, 1=SUB, 2=ADDS (saturating add), 3=SUBS (saturating sub)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  raw carry-out of MSB; for SUB/SUBS, 1 means no borrow
flag_z  out  1  sum == 0, evaluated after saturation
flag_v  out  1  signed overflow of the unsaturated operation
flag_n  out  1  sum[WIDTH-1], evaluated after saturation

Behaviour:
- Transfer rule: a transfer occurs on any edge where valid && ready.
- Subtraction: SUB/SUBS compute a + ~b + 1. Invert b and force carry-in = 1.
- Stage 1, accept:
  - Per bit: p = a|b', g = a&b', s = a^b'^c.
  - Group P/G are formed per GROUP. The lower WIDTH/2 bits are computed fully.
  - Registered: lower sum, carry into bit WIDTH/2, upper a and b', mode.
- Stage 2:
  - Compute upper WIDTH/2 bits from the registered carry.
  - V = (a_msb == b'_msb) && (raw_sum_msb != a_msb).
  - Saturation: if mode is ADDS/SUBS and V=1, sum = 0 1…1 when a_msb=0, else 1 0…0.
  - All outputs come from the stage-2 registers.
- Latency: exactly 2 cycles from accept to out_valid when out_ready is held 1. Throughput is 1 result per cycle.
- Handshake and flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational; it does not depend on in_valid).
  - out_valid = s2_valid.
  - sum and flags hold stable while out_valid && !out_ready.
- Simultaneous events:
  - Accept while stage 2 drains: both advance in the same edge.
  - When full with out_ready=0, in_ready=0. Nothing is dropped or duplicated, and order is preserved.
- Reset (rst_n=0, asynchronous):
  - s1_valid, s2_valid, out_valid = 0; sum = 0; cout, flag_z, flag_v, flag_n = 0. flag_z resets to 0, not 1.
  - in_ready = 1 once rst_n is high.
  - Reset mid-operation discards all in-flight results. No output is emitted for them.
- Width rules:
  - cout is the true carry out of bit WIDTH-1 before saturation.
  - The carry chain inside a group is lookahead, not ripple: c[i+1] = g[i] | p[i]&c[i], expanded per group.
- Unknown mode values cannot occur (2-bit fully decoded).

Decomposition:
- Shared package: mode encodings (ADD, SUB, ADDS, SUBS) and the saturation constant helpers (max_pos/max_neg as WIDTH functions).
- One sub-module: cla_group. GROUP-bit lookahead block with inputs a, b, cin and outputs sum, group P, group G. It is instantiated WIDTH/GROUP times.
- Top level: carry logic between groups and the pipeline/handshake registers.

Test Plan:
1. WIDTH=16, ADD a=0x7FFF b=0x0001, out_ready=1 -> 2 cycles later sum=0x8000, V=1, N=1, Z=0, cout=0.
2. ADDS a=0x7FFF b=0x0001 -> sum=0x7FFF, V=1, N=0. SUBS a=0x8000 b=0x0001 -> sum=0x8000, V=1, N=1.
3. SUB a=0x0005 b=0x0005 -> sum=0x0000, Z=1, cout=1, V=0. SUB a=0x0003 b=0x0005 -> sum=0xFFFE, N=1, cout=0.
4. Backpressure: out_ready=0, in_valid=1 with three operand sets -> first two accepted and in_ready=0 on the third. Raise out_ready -> results emerge in order, one per cycle, sum stable while stalled.
5. Back-to-back random stream with out_ready toggling randomly, compared against a reference model -> zero mismatches, no loss or duplication.
6. Assert rst_n=0 with two ops in flight -> out_valid=0 and all outputs 0 immediately (asynchronous). After release, in_ready=1 and no stale result ever appears.
